// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I control path: opcodes, immediate kinds,
// FSM states and datapath mux codes.
package rv32_ctrl_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;
   localparam logic [2:0] IMM_U    = 3'd5;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd7
   } ctrl_state_e;

   localparam logic [1:0] PCSEL_PC4 = 2'd0;
   localparam logic [1:0] PCSEL_IMM = 2'd1;
   localparam logic [1:0] PCSEL_ALU = 2'd2;

   localparam logic [1:0] WBSEL_ALU = 2'd0;
   localparam logic [1:0] WBSEL_MEM = 2'd1;
   localparam logic [1:0] WBSEL_PC4 = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_BR    = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_PASSB = 2'd3;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: immediate kind plus instruction-class flags.
// Shared between the multi-cycle and pipelined control paths.
module opcode_class
   import rv32_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] imm_sel,
   output logic       is_load,
   output logic       is_store,
   output logic       is_branch,
   output logic       is_jump,
   output logic       legal
);

   always_comb begin
      imm_sel   = IMM_NONE;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      legal     = 1'b1;
      case (opcode)
         OPC_OP:     imm_sel = IMM_NONE;
         OPC_OPIMM:  imm_sel = IMM_I;
         OPC_LOAD: begin
            imm_sel = IMM_I;
            is_load = 1'b1;
         end
         OPC_STORE: begin
            imm_sel  = IMM_S;
            is_store = 1'b1;
         end
         OPC_BRANCH: begin
            imm_sel   = IMM_B;
            is_branch = 1'b1;
         end
         OPC_JAL: begin
            imm_sel = IMM_J;
            is_jump = 1'b1;
         end
         OPC_JALR: begin
            imm_sel = IMM_I;
            is_jump = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
         // Also catches every non-32-bit encoding (opcode[1:0] != 2'b11).
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM: fetch, decode, execute, memory, writeback.
// Define MULTICYCLE_CTRL_PERF_EN to add cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl
   import rv32_ctrl_pkg::*;
#(
   parameter bit RESET_STATE_FETCH = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] Instr,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        IRWrite,
   output logic [2:0]  ImmSel,
   output logic        ALUSrcA,
   output logic        ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic        RegWrite,
   output logic [1:0]  WBSel,
   output logic        PCWrite,
   output logic [1:0]  PCSel,
   output logic        illegal,
   output logic [2:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   localparam ctrl_state_e ResetState = RESET_STATE_FETCH ? StFetch : StHalt;

   ctrl_state_e state_q, state_d;
   logic [2:0]  imm_sel_q, imm_sel_d;

   logic [6:0] opcode;
   logic [2:0] cls_imm_sel;
   logic       is_load, is_store, is_branch, is_jump, legal;
   logic       unused_instr;

   assign opcode       = Instr[6:0];
   assign unused_instr = ^Instr[31:7];

   opcode_class u_opcode_class (
      .opcode    (opcode),
      .imm_sel   (cls_imm_sel),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_branch (is_branch),
      .is_jump   (is_jump),
      .legal     (legal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ResetState;
         imm_sel_q <= IMM_NONE;
      end else begin
         state_q   <= state_d;
         imm_sel_q <= imm_sel_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      imm_sel_d = imm_sel_q;
      imem_req  = 1'b0;
      IRWrite   = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALUOP_ADD;
      dmem_rd   = 1'b0;
      dmem_wr   = 1'b0;
      RegWrite  = 1'b0;
      WBSel     = WBSEL_ALU;
      PCWrite   = 1'b0;
      PCSel     = PCSEL_PC4;
      illegal   = 1'b0;

      unique case (state_q)
         StHalt: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWrite = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (!legal) begin
               illegal = 1'b1;
               PCWrite = 1'b1;
               state_d = StFetch;
            end else begin
               imm_sel_d = cls_imm_sel;
               state_d   = StExec;
            end
         end
         StExec: begin
            if (is_branch) begin
               ALUOp   = ALUOP_BR;
               PCWrite = 1'b1;
               PCSel   = branch_taken ? PCSEL_IMM : PCSEL_PC4;
               state_d = StFetch;
            end else begin
               state_d = StWb;
               case (opcode)
                  OPC_OP: ALUOp = ALUOP_FUNCT;
                  OPC_OPIMM: begin
                     ALUSrcB = 1'b1;
                     ALUOp   = ALUOP_FUNCT;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     ALUSrcB = 1'b1;
                     state_d = StMem;
                  end
                  OPC_AUIPC, OPC_JAL: begin
                     ALUSrcA = 1'b1;
                     ALUSrcB = 1'b1;
                  end
                  OPC_LUI: begin
                     ALUSrcB = 1'b1;
                     ALUOp   = ALUOP_PASSB;
                  end
                  OPC_JALR: ALUSrcB = 1'b1;
                  // IR changed under us: skip the instruction so PC still advances once.
                  default: begin
                     PCWrite = 1'b1;
                     state_d = StFetch;
                  end
               endcase
            end
         end
         StMem: begin
            dmem_rd = is_load;
            dmem_wr = is_store;
            if (dmem_ready) begin
               if (is_load) begin
                  state_d = StWb;
               end else begin
                  PCWrite = 1'b1;
                  state_d = StFetch;
               end
            end
         end
         StWb: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = StFetch;
            if (is_load) begin
               WBSel = WBSEL_MEM;
            end else if (is_jump) begin
               WBSel = WBSEL_PC4;
            end
            if (opcode == OPC_JAL) begin
               PCSel = PCSEL_IMM;
            end else if (opcode == OPC_JALR) begin
               PCSel = PCSEL_ALU;
            end
         end
         default: state_d = ResetState;
      endcase

      if (state_d == StFetch) imm_sel_d = IMM_NONE;

      // Outputs are forced quiet during reset so an aborted instruction never retires.
      if (!rst_n) begin
         imem_req = 1'b0;
         IRWrite  = 1'b0;
         ALUSrcA  = 1'b0;
         ALUSrcB  = 1'b0;
         ALUOp    = ALUOP_ADD;
         dmem_rd  = 1'b0;
         dmem_wr  = 1'b0;
         RegWrite = 1'b0;
         WBSel    = WBSEL_ALU;
         PCWrite  = 1'b0;
         PCSel    = PCSEL_PC4;
         illegal  = 1'b0;
      end
   end

   assign ImmSel  = imm_sel_q;
   assign state_o = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_q, instret_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_q   <= 32'd0;
         instret_q <= 32'd0;
      end else begin
         if (state_q != StHalt) cycle_q <= cycle_q + 32'd1;
         if (PCWrite && !illegal) instret_q <= instret_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a per-instruction scoreboard of
// expected retirement behaviour.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        start_h;
   logic [31:0] Instr;
   logic        imem_ready, dmem_ready, branch_taken;
   logic        imem_req, IRWrite, ALUSrcA, ALUSrcB, dmem_rd, dmem_wr;
   logic        RegWrite, PCWrite, illegal;
   logic [2:0]  ImmSel, state_o;
   logic [1:0]  ALUOp, WBSel, PCSel;

   logic        imem_req_h, IRWrite_h, ALUSrcA_h, ALUSrcB_h, dmem_rd_h, dmem_wr_h;
   logic        RegWrite_h, PCWrite_h, illegal_h;
   logic [2:0]  ImmSel_h, state_h;
   logic [1:0]  ALUOp_h, WBSel_h, PCSel_h;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt, cycle_cnt_h, instret_cnt_h;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0] imm;
      logic [1:0] aluop;
      logic       srca;
      logic       srcb;
      logic [1:0] pcsel;
      logic [1:0] wbsel;
      logic       rw;
      logic       ill;
      int         cyc;
      int         rdn;
      int         wrn;
   } exp_t;

   exp_t sb[$];

   multicycle_ctrl #(.RESET_STATE_FETCH(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Instr(Instr),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .imem_req(imem_req), .IRWrite(IRWrite), .ImmSel(ImmSel), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
      .RegWrite(RegWrite), .WBSel(WBSel), .PCWrite(PCWrite), .PCSel(PCSel),
      .illegal(illegal), .state_o(state_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   multicycle_ctrl #(.RESET_STATE_FETCH(1'b0)) dut_h (
      .clk(clk), .rst_n(rst_n), .start(start_h), .Instr(Instr),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .imem_req(imem_req_h), .IRWrite(IRWrite_h), .ImmSel(ImmSel_h), .ALUSrcA(ALUSrcA_h),
      .ALUSrcB(ALUSrcB_h), .ALUOp(ALUOp_h), .dmem_rd(dmem_rd_h), .dmem_wr(dmem_wr_h),
      .RegWrite(RegWrite_h), .WBSel(WBSel_h), .PCWrite(PCWrite_h), .PCSel(PCSel_h),
      .illegal(illegal_h), .state_o(state_h)
`ifdef MULTICYCLE_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt_h), .instret_cnt(instret_cnt_h)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected behaviour straight from the opcode table; cycle indices count from
   // the first FETCH cycle of the instruction.
   function automatic exp_t model(input logic [31:0] ins, input logic taken,
                                  input int iw, input int mw);
      exp_t e;
      logic [6:0] op;
      e = '{imm: 3'd0, aluop: 2'd0, srca: 1'b0, srcb: 1'b0, pcsel: 2'd0, wbsel: 2'd0,
            rw: 1'b0, ill: 1'b0, cyc: 0, rdn: 0, wrn: 0};
      op = ins[6:0];
      case (op)
         7'b0110011: begin e.aluop = 2; e.rw = 1; e.cyc = 3; end
         7'b0010011: begin e.imm = 1; e.srcb = 1; e.aluop = 2; e.rw = 1; e.cyc = 3; end
         7'b0110111: begin e.imm = 5; e.srcb = 1; e.aluop = 3; e.rw = 1; e.cyc = 3; end
         7'b0010111: begin e.imm = 5; e.srca = 1; e.srcb = 1; e.rw = 1; e.cyc = 3; end
         7'b1101111: begin
            e.imm = 4; e.srca = 1; e.srcb = 1; e.rw = 1; e.wbsel = 2; e.pcsel = 1; e.cyc = 3;
         end
         7'b1100111: begin
            e.imm = 1; e.srcb = 1; e.rw = 1; e.wbsel = 2; e.pcsel = 2; e.cyc = 3;
         end
         7'b1100011: begin e.imm = 3; e.aluop = 1; e.pcsel = {1'b0, taken}; e.cyc = 2; end
         7'b0000011: begin
            e.imm = 1; e.srcb = 1; e.rw = 1; e.wbsel = 1; e.cyc = 4 + mw; e.rdn = mw + 1;
         end
         7'b0100011: begin e.imm = 2; e.srcb = 1; e.cyc = 3 + mw; e.wrn = mw + 1; end
         default: begin e.ill = 1; e.cyc = 1; end
      endcase
      e.cyc += iw;
      return e;
   endfunction

   task automatic run(input string name, input logic [31:0] ins, input logic taken,
                      input int iw, input int mw);
      exp_t e;
      int cyc, fcnt, mcnt, rd_n, wr_n, rw_n, ill_n;
      bit done;
      sb.push_back(model(ins, taken, iw, mw));
      Instr = ins;
      branch_taken = taken;
      cyc = 0; fcnt = 0; mcnt = 0; rd_n = 0; wr_n = 0; rw_n = 0; ill_n = 0; done = 0;
      while (!done && cyc < 40) begin
         imem_ready = !(state_o == 3'd0 && fcnt < iw);
         dmem_ready = !(state_o == 3'd3 && mcnt < mw);
         #1;
         if (state_o == 3'd0) fcnt++;
         if (state_o == 3'd3) mcnt++;
         if (dmem_rd) rd_n++;
         if (dmem_wr) wr_n++;
         if (RegWrite) rw_n++;
         if (illegal) ill_n++;
         if (cyc == 0) chk({name, ".imem_req"}, imem_req, 1);
         if (cyc == iw) chk({name, ".IRWrite"}, IRWrite, 1);
         if (cyc == iw + 2 && !sb[0].ill) begin
            chk({name, ".ImmSel"}, ImmSel, sb[0].imm);
            chk({name, ".ALUOp"}, ALUOp, sb[0].aluop);
            chk({name, ".ALUSrc"}, {ALUSrcA, ALUSrcB}, {sb[0].srca, sb[0].srcb});
         end
         if (PCWrite) begin
            if (sb.size() == 0) begin
               chk({name, ".sb_empty"}, 0, 1);
            end else begin
               e = sb.pop_front();
               chk({name, ".cycle"}, cyc, e.cyc);
               chk({name, ".PCSel"}, PCSel, e.pcsel);
               chk({name, ".WBSel"}, WBSel, e.wbsel);
               chk({name, ".illegal_cnt"}, ill_n, e.ill);
               chk({name, ".RegWrite_cnt"}, rw_n, e.rw);
               chk({name, ".dmem_rd_cnt"}, rd_n, e.rdn);
               chk({name, ".dmem_wr_cnt"}, wr_n, e.wrn);
            end
            done = 1;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) begin
         chk({name, ".timeout"}, 0, 1);
         sb.delete();
      end
      chk({name, ".back_fetch"}, state_o, 0);
      chk({name, ".ImmSel_fetch"}, ImmSel, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_h = 1'b0; Instr = 32'd0;
      imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
      #1;
      tick();
      tick();
      chk("rst.state", state_o, 0);
      chk("rst.outs", {imem_req, IRWrite, ALUSrcA, ALUSrcB, ALUOp, dmem_rd, dmem_wr,
                       RegWrite, WBSel, PCWrite, PCSel, illegal}, 0);
      chk("rst.ImmSel", ImmSel, 0);
      chk("rst.halt_state", state_h, 7);
`ifdef MULTICYCLE_CTRL_PERF_EN
      chk("rst.cycle_cnt", cycle_cnt, 0);
      chk("rst.instret_cnt", instret_cnt, 0);
`endif
      rst_n = 1'b1;

      run("addi", 32'h00500093, 1'b0, 0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
      chk("perf.instret", instret_cnt, 1);
      chk("perf.cycle", cycle_cnt, 4);
`endif
      run("beq_t", 32'h00000463, 1'b1, 0, 0);
      run("beq_nt", 32'h00000463, 1'b0, 0, 0);
      run("lw_wait", 32'h0000A103, 1'b0, 0, 3);
      run("jal", 32'h008000EF, 1'b0, 0, 0);
      run("jalr", 32'h000080E7, 1'b0, 0, 0);
      run("ill_ff", 32'hFFFFFFFF, 1'b0, 0, 0);
      run("sw", 32'h0020A023, 1'b0, 0, 0);
      run("add", 32'h002081B3, 1'b1, 0, 0);
      run("lui", 32'h123450B7, 1'b0, 0, 0);
      run("auipc", 32'h00001097, 1'b0, 0, 0);
      run("addi_iw", 32'h00500093, 1'b0, 2, 0);
      run("ill_16b", 32'h00500090, 1'b0, 0, 0);
      run("ill_fence", 32'h0000000F, 1'b0, 1, 0);
      run("sw_wait", 32'h0020A023, 1'b0, 1, 2);

      // Reset while a store is waiting in MEM.
      Instr = 32'h0020A023; imem_ready = 1'b1; dmem_ready = 1'b0;
      tick(); tick(); tick();
      chk("abort.in_mem", state_o, 3);
      chk("abort.dmem_wr_before", dmem_wr, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.rst_pcwrite", PCWrite, 0);
      chk("abort.rst_dmem_wr", dmem_wr, 0);
      tick();
      rst_n = 1'b1; dmem_ready = 1'b1;
      #1;
      chk("abort.state", state_o, 0);
      chk("abort.dmem_wr", dmem_wr, 0);
      chk("abort.pcwrite", PCWrite, 0);
      chk("abort.imem_req", imem_req, 1);

      run("addi_after", 32'h00500093, 1'b0, 0, 0);

      chk("halt.state", state_h, 7);
      chk("halt.outs", {imem_req_h, IRWrite_h, dmem_rd_h, dmem_wr_h, RegWrite_h,
                        PCWrite_h, illegal_h}, 0);
      start_h = 1'b1;
      tick();
      start_h = 1'b0;
      #1;
      chk("halt.to_fetch", state_h, 0);
      chk("halt.fetch_req", imem_req_h, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback, one instruction at a time.
- Drives the immediate generator's 3-bit ImmSel, IR/PC write enables, datapath mux selects and memory strobes.
- Sits between the instruction register, the ALU/branch compare and the instruction/data memory ready signals.

Parameters:
- RESET_STATE_FETCH, 1, when 1, reset enters FETCH; when 0, reset enters HALT until `start` is seen high.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  leave HALT (used only when RESET_STATE_FETCH=0)
- Instr  in  32  instruction register contents; stable after IRWrite
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory access complete this cycle
- branch_taken  in  1  branch compare result, valid in EXEC
- imem_req  out  1  instruction fetch request
- IRWrite  out  1  load instruction register
- ImmSel  out  3  0 none, 1 I, 2 S, 3 B, 4 J, 5 U
- ALUSrcA  out  1  0 rs1, 1 PC
- ALUSrcB  out  1  0 rs2, 1 immediate
- ALUOp  out  2  0 add, 1 branch compare, 2 funct-decoded, 3 pass-B (LUI)
- dmem_rd  out  1  data read strobe
- dmem_wr  out  1  data write strobe
- RegWrite  out  1  register file write enable
- WBSel  out  2  0 ALU, 1 memory, 2 PC+4
- PCWrite  out  1  update PC (one-cycle pulse)
- PCSel  out  2  0 PC+4, 1 PC+imm, 2 ALU result & ~1
- illegal  out  1  one-cycle pulse on unsupported opcode
- state_o  out  3  current state (debug)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Reset (rst_n low at a clk edge):
  - State goes to FETCH, or HALT when RESET_STATE_FETCH=0.
  - All outputs 0, ImmSel=0.
  - Reset mid-operation aborts the instruction. No PCWrite or RegWrite is issued.
- HALT: all outputs 0. `start` high -> FETCH next cycle.
- FETCH:
  - imem_req=1. Stays in FETCH while imem_ready=0.
  - imem_ready=1 -> IRWrite=1 for that cycle, then DECODE.
  - ImmSel=0 throughout.
- DECODE:
  - ImmSel register loaded from Instr[6:0]: OP-IMM/LOAD/JALR -> 1, STORE -> 2, BRANCH -> 3, JAL -> 4, LUI/AUIPC -> 5, OP -> 0.
  - ImmSel holds from the cycle after DECODE until the next FETCH.
  - Unsupported opcode (incl. Instr[1:0]!=2'b11) -> illegal=1, PCWrite=1 with PCSel=0, return to FETCH (instruction skipped).
  - Otherwise -> EXEC.
- EXEC, per opcode:
  - OP: A=rs1, B=rs2, ALUOp=2.
  - OP-IMM: A=rs1, B=imm, ALUOp=2.
  - LOAD/STORE: A=rs1, B=imm, ALUOp=0.
  - AUIPC: A=PC, B=imm, ALUOp=0.
  - LUI: B=imm, ALUOp=3.
  - JAL/JALR: A=PC or rs1, B=imm, ALUOp=0.
  - BRANCH: ALUOp=1. PCWrite=1, PCSel = branch_taken ? 1 : 0. -> FETCH.
  - LOAD/STORE -> MEM. All others -> WB.
- MEM:
  - dmem_rd (LOAD) or dmem_wr (STORE) asserted and held until dmem_ready=1.
  - On dmem_ready: LOAD -> WB; STORE -> PCWrite=1, PCSel=0 -> FETCH.
- WB:
  - RegWrite=1 for one cycle. WBSel: LOAD=1, JAL/JALR=2, else 0.
  - PCWrite=1 with PCSel: JAL=1, JALR=2, else 0. -> FETCH.
- The rd=x0 write is not suppressed here; the register file handles it.
- Cycle counts with zero-wait memories:
  - R/I/U: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Simultaneous imem_ready and dmem_ready: only the signal relevant to the current state is sampled.
- Exactly one PCWrite pulse per retired or skipped instruction.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - Both cleared by reset.
  - cycle_cnt increments every cycle outside HALT.
  - instret_cnt increments on each PCWrite pulse where illegal=0.
  - Both wrap from 32'hFFFFFFFF to 0.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package, rv32_ctrl_pkg:
  - opcode localparams (OPC_LUI=7'b0110111, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP);
  - ImmSel codes IMM_NONE..IMM_U (0..5);
  - state encodings;
  - PCSel, WBSel and ALUOp codes.
- One natural sub-module, opcode_class: combinational Instr[6:0] -> {imm_sel, is_load, is_store, is_branch, is_jump, legal}. It is reused by the pipelined core later.

Test Plan:
- ADDI 0x00500093, imem_ready=1 every cycle -> IRWrite in cycle 0; ImmSel=1 from cycle 2; RegWrite and PCWrite (PCSel=0) in cycle 3; back in FETCH at cycle 4.
- BEQ 0x00000463 with branch_taken=1 -> ImmSel=3; PCWrite with PCSel=1 in EXEC; no RegWrite. Repeat with branch_taken=0 -> PCSel=0.
- LW 0x0000A103, dmem_ready held low for 3 MEM cycles -> dmem_rd high for 4 cycles; WB with WBSel=1, RegWrite=1; 8 cycles total.
- JAL 0x008000EF -> ImmSel=4; WB with WBSel=2, PCSel=1. JALR 0x000080E7 -> ImmSel=1, PCSel=2.
- Illegal 0xFFFFFFFF -> illegal pulse in DECODE, PCWrite with PCSel=0, no RegWrite, no dmem strobes.
- rst_n low during MEM of SW 0x0020A023 -> next cycle state=FETCH, dmem_wr=0, no PCWrite. With perf macro: both counters 0 after reset; instret_cnt=1 after one ADDI.
